pmod_sonar_array_ctrlr: RTL and testbench
=========================================

Name: pmod_sonar_array_ctrlr

Overview:
Wishbone-attached controller for up to four HC-SR04-class ultrasonic sensors on a PMOD header. Generates trigger pulses in hardware and measures echo pulse width in i_clk cycles. Channels fire one at a time, round-robin, to avoid acoustic crosstalk; each channel has its own result register.
Supports single-shot and continuous modes, with a timeout. Replaces the single-channel, status-only sensor controller.

Parameters:
N_CH, 2, number of sensor channels (1..4)
CNT_W, 24, echo width counter / result width (≤ 30)
TRIG_CYCLES, 640, trigger high time in i_clk cycles (10 us @ 64 MHz)
TIMEOUT_CYCLES, 2_560_000, max cycles in WAIT_RISE or MEASURE before abort (40 ms)
GAP_CYCLES, 3_840_000, holdoff after each channel before next trigger (60 ms)

Ports:
i_clk  in  1  system clock; the only clock
i_rst  in  1  asynchronous, active-high reset
i_wb_adr  in  6  byte address; word select = i_wb_adr[5:2]
i_wb_dat  in  32  write data
i_wb_sel  in  4  byte lane enables
i_wb_we  in  1  write enable
i_wb_cyc  in  1  bus cycle valid
i_wb_stb  in  1  strobe
o_wb_dat  out  32  read data
o_wb_ack  out  1  acknowledge
o_trigger  out  N_CH  per-channel trigger outputs
i_echo  in  N_CH  per-channel echo inputs, asynchronous

Behaviour:
- Reset (async assert, sync release): o_wb_ack=0, o_wb_dat=0, o_trigger=0, all registers 0, FSM=IDLE, ch=0.
- Echo inputs pass through a 2-FF synchroniser per channel; the FSM sees echo 2 cycles late.
- Wishbone: o_wb_ack pulses 1 cycle after cyc&stb with ack low, i.e. 1-cycle latency, never back-to-back. Read data is registered and valid with ack. Write takes effect on the ack cycle. Writes honour i_wb_sel per byte.
- Register map:
  - 0x00 CTRL: [0] EN, [1] CONT, [2] START (write-1 self-clearing, reads 0), [7:4] CH_MASK (bits ≥ N_CH ignored).
  - 0x04 STATUS, read-only: [0] BUSY, [2:1] CUR_CH, [11:8] DONE[ch], [19:16] TMO[ch], [27:24] raw synchronised echo.
  - 0x08 CLR, write-only: write 1 to bit n clears DONE[n] and TMO[n].
  - 0x10+4n RESULT[n]: [CNT_W-1:0] last echo width, upper bits 0.
  - Unmapped reads return 0; unmapped writes are ignored.
- FSM: IDLE -> TRIG -> WAIT_RISE -> MEASURE -> GAP -> (next or IDLE).
  - IDLE: leave when EN=1 and (START written or CONT=1) and CH_MASK≠0. Select the lowest enabled channel at or after ch; ch wraps from N_CH-1 to 0.
  - TRIG: o_trigger[ch]=1 for exactly TRIG_CYCLES cycles, then 0.
  - WAIT_RISE: wait for synchronised echo=1. If TIMEOUT_CYCLES elapse first: TMO[ch]=1, DONE[ch]=1, RESULT unchanged, go to GAP.
  - MEASURE: counter increments each cycle echo=1. On the falling edge: RESULT[ch]=count, DONE[ch]=1, TMO[ch]=0, go to GAP. If count reaches TIMEOUT_CYCLES: RESULT[ch]=TIMEOUT_CYCLES, TMO[ch]=1, DONE[ch]=1, go to GAP. The counter saturates at 2^CNT_W-1.
  - GAP: wait GAP_CYCLES, then advance to the next enabled channel.
    - Single-shot: return to IDLE after the last enabled channel in ascending order has completed once.
    - Continuous: loop indefinitely.
- BUSY=1 whenever the FSM is not in IDLE. START while BUSY is ignored.
- EN cleared mid-operation: o_trigger=0 immediately (same cycle as the write takes effect); FSM goes to IDLE next cycle. RESULT, DONE and TMO are kept.
- CLR on the same cycle the FSM sets DONE[n]: the set wins.
- Async reset mid-pulse: o_trigger drops asynchronously.

Test Plan:
- N_CH=2, TRIG_CYCLES=8. Write CTRL=0x31 (EN, mask 0b11), then START. Expected: o_trigger[0] high exactly 8 cycles; trigger[1] only after ch0 GAP; BUSY returns 0 after ch1 GAP.
- Echo0 high for 1000 cycles after trigger. Expected: RESULT[0]=1000, DONE[0]=1, TMO[0]=0; STATUS read matches with ack one cycle after stb.
- Echo never rises, TIMEOUT_CYCLES=200. Expected: TMO[0]=1 and DONE[0]=1 about 200 cycles after trigger falls; RESULT[0] unchanged.
- Echo stuck high. Expected: RESULT[0]=TIMEOUT_CYCLES, TMO[0]=1; write CLR=0x1 clears both flags.
- CONT=1, mask=0b10. Expected: only o_trigger[1] pulses, periodically. Clear EN mid-TRIG: trigger drops, BUSY=0 within 2 cycles.
- Assert i_rst asynchronously during MEASURE. Expected: all outputs 0 immediately; after release, registers read 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/pmod_sonar_array_ctrlr.sv
// Round-robin ultrasonic sensor array controller: hardware trigger pulses, per-channel echo
// width capture with timeout, and a Wishbone register file.
// Valid/ready: a bus request is taken when cyc&stb are high and ack is low; ack answers it exactly one cycle later.
module pmod_sonar_array_ctrlr #(
    parameter int N_CH           = 2,
    parameter int CNT_W          = 24,
    parameter int TRIG_CYCLES    = 640,
    parameter int TIMEOUT_CYCLES = 2_560_000,
    parameter int GAP_CYCLES     = 3_840_000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [5:0]      i_wb_adr,
    input  logic [31:0]     i_wb_dat,
    input  logic [3:0]      i_wb_sel,
    input  logic            i_wb_we,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    output logic [31:0]     o_wb_dat,
    output logic            o_wb_ack,
    output logic [N_CH-1:0] o_trigger,
    input  logic [N_CH-1:0] i_echo,
    output logic [2:0]      o_dbg_state
);

    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_GAP} state_t;

    localparam logic [3:0]       CH_VALID = 4'((1 << N_CH) - 1);
    localparam logic [31:0]      CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0]      TMO_LIM  = 32'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_RES  = (TMO_LIM > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(TMO_LIM);

    logic             ack_q, en_q, cont_q, start_q;
    logic [31:0]      dat_q, rd_data;
    logic [3:0]       mask_q, done_q, done_d, tmo_q, tmo_d;
    logic [3:0]       set_done, set_tmo, clr_tmo, clr_bits, ch_oh, echo4;
    logic [CNT_W-1:0] result_q [N_CH];
    logic [CNT_W-1:0] cnt_q, cnt_d, res_val;
    logic             res_we;
    state_t           state_q, state_d;
    logic [1:0]       ch_q, ch_d;
    logic [31:0]      tmr_q, tmr_d, cnt_inc;
    logic [N_CH-1:0]  echo_m_q, echo_s_q;
    logic [2:0]       pk_idle, pk_next;
    logic             wb_acc, wr, rd, echo_cur;
    logic [3:0]       word;
    logic             unused_ok;

    // Returns {found, channel}: first channel enabled in m at or after 'from', wrapping.
    function automatic logic [2:0] pick_ch(input logic [1:0] from, input logic [3:0] m);
        logic [2:0] r;
        int c;
        r = 3'b000;
        for (int i = N_CH - 1; i >= 0; i--) begin
            c = (int'(from) + i) % N_CH;
            if (m[c]) r = {1'b1, c[1:0]};
        end
        return r;
    endfunction

    assign wb_acc    = i_wb_cyc & i_wb_stb & ~ack_q;
    assign wr        = wb_acc & i_wb_we;
    assign rd        = wb_acc & ~i_wb_we;
    assign word      = i_wb_adr[5:2];
    assign clr_bits  = (wr && word == 4'd2 && i_wb_sel[0]) ? (i_wb_dat[3:0] & CH_VALID) : 4'd0;
    assign ch_oh     = 4'b0001 << ch_q;
    assign echo4     = 4'(echo_s_q);
    assign echo_cur  = echo4[ch_q];
    assign cnt_inc   = 32'(cnt_q) + 32'd1;
    assign pk_idle   = pick_ch(ch_q, mask_q);
    assign pk_next   = pick_ch(ch_q + 2'd1, mask_q);
    assign unused_ok = ^{i_wb_dat[31:8], i_wb_sel[3:1], i_wb_adr[1:0]};

    assign o_wb_ack    = ack_q;
    assign o_wb_dat    = dat_q;
    assign o_dbg_state = state_q;
    // Gated by en_q so clearing EN drops the trigger in the very cycle the write lands.
    assign o_trigger   = (state_q == S_TRIG && en_q) ? ch_oh[N_CH-1:0] : '0;

    always_comb begin
        rd_data = 32'd0;
        case (word)
            4'd0: rd_data = {24'd0, mask_q, 2'b00, cont_q, en_q};
            4'd1: rd_data = {4'd0, echo4, 4'd0, tmo_q, 4'd0, done_q, 5'd0, ch_q, state_q != S_IDLE};
            default: begin
                for (int n = 0; n < N_CH; n++)
                    if (word == 4'(4 + n)) rd_data = 32'(result_q[n]);
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        tmr_d    = tmr_q;
        cnt_d    = cnt_q;
        set_done = 4'd0;
        set_tmo  = 4'd0;
        clr_tmo  = 4'd0;
        res_we   = 1'b0;
        res_val  = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (en_q && (start_q || cont_q) && pk_idle[2]) begin
                    state_d = S_TRIG;
                    ch_d    = pk_idle[1:0];
                    tmr_d   = 32'd0;
                end
            end
            S_TRIG: begin
                if (tmr_q == 32'(TRIG_CYCLES - 1)) begin
                    state_d = S_WAIT_RISE;
                    tmr_d   = 32'd0;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            S_WAIT_RISE: begin
                if (echo_cur) begin
                    // The cycle that sees the rising edge is the first counted cycle.
                    state_d = S_MEASURE;
                    cnt_d   = CNT_W'(1);
                end else if (tmr_q == TMO_LIM - 32'd1) begin
                    set_done = ch_oh;
                    set_tmo  = ch_oh;
                    state_d  = S_GAP;
                    tmr_d    = 32'd0;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            S_MEASURE: begin
                if (!echo_cur) begin
                    res_we   = 1'b1;
                    set_done = ch_oh;
                    clr_tmo  = ch_oh;
                    state_d  = S_GAP;
                    tmr_d    = 32'd0;
                end else if (cnt_inc >= TMO_LIM) begin
                    res_we   = 1'b1;
                    res_val  = TMO_RES;
                    set_done = ch_oh;
                    set_tmo  = ch_oh;
                    state_d  = S_GAP;
                    tmr_d    = 32'd0;
                end else if (32'(cnt_q) != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (tmr_q == 32'(GAP_CYCLES - 1)) begin
                    tmr_d = 32'd0;
                    if (cont_q) begin
                        state_d = pk_next[2] ? S_TRIG : S_IDLE;
                        if (pk_next[2]) ch_d = pk_next[1:0];
                    end else if (pk_next[2] && pk_next[1:0] > ch_q) begin
                        state_d = S_TRIG;
                        ch_d    = pk_next[1:0];
                    end else begin
                        // Single-shot sweep finished; the next sweep starts from channel 0.
                        state_d = S_IDLE;
                        ch_d    = 2'd0;
                    end
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!en_q && state_q != S_IDLE) state_d = S_IDLE;
    end

    assign done_d = (done_q & ~clr_bits) | set_done;
    assign tmo_d  = (tmo_q & ~clr_bits & ~clr_tmo) | set_tmo;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
            en_q     <= 1'b0;
            cont_q   <= 1'b0;
            start_q  <= 1'b0;
            mask_q   <= 4'd0;
            done_q   <= 4'd0;
            tmo_q    <= 4'd0;
            state_q  <= S_IDLE;
            ch_q     <= 2'd0;
            tmr_q    <= 32'd0;
            cnt_q    <= '0;
            echo_m_q <= '0;
            echo_s_q <= '0;
            for (int n = 0; n < N_CH; n++) result_q[n] <= '0;
        end else begin
            ack_q    <= wb_acc;
            dat_q    <= rd ? rd_data : 32'd0;
            start_q  <= wr && word == 4'd0 && i_wb_sel[0] && i_wb_dat[2];
            if (wr && word == 4'd0 && i_wb_sel[0]) begin
                en_q   <= i_wb_dat[0];
                cont_q <= i_wb_dat[1];
                mask_q <= i_wb_dat[7:4] & CH_VALID;
            end
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            state_q  <= state_d;
            ch_q     <= ch_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            echo_m_q <= i_echo;
            echo_s_q <= echo_m_q;
            for (int n = 0; n < N_CH; n++)
                if (res_we && ch_q == 2'(n)) result_q[n] <= res_val;
        end
    end

endmodule

// File: tb/tb_pmod_sonar_array_ctrlr.sv
// Bench for pmod_sonar_array_ctrlr: sensor models answer each trigger with a random echo,
// and bus reads are scored against a register-level model of the expected results.
module tb_pmod_sonar_array_ctrlr;

    localparam int N_CH = 2;
    localparam int CNT_W = 16;
    localparam int TRIG = 8;
    localparam int TMO = 200;
    localparam int GAP = 50;

    logic            clk, rst;
    logic [5:0]      wb_adr;
    logic [31:0]     wb_dat, wb_dat_o;
    logic [3:0]      wb_sel;
    logic            wb_we, wb_cyc, wb_stb, wb_ack;
    logic [N_CH-1:0] trig;
    wire  [N_CH-1:0] echo_w;
    logic [2:0]      dbg_state;

    int checks = 0;
    int fails = 0;
    int cyc_n = 0;
    int prev_fall = -1;
    int width_a [N_CH];
    int pulse_cnt [N_CH];
    int exp_res [N_CH];
    logic abort_flag [N_CH];
    logic [N_CH-1:0] trig_at_ack;

    logic [31:0] exp_q[$];
    logic [31:0] msk_q[$];
    string       name_q[$];

    pmod_sonar_array_ctrlr #(
        .N_CH(N_CH), .CNT_W(CNT_W), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
        .i_wb_we(wb_we), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .o_wb_dat(wb_dat_o),
        .o_wb_ack(wb_ack), .o_trigger(trig), .i_echo(echo_w), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #900_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // ---------------- sensor models + trigger monitor ----------------
    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_sensor
            logic echo_r;
            assign echo_w[g] = echo_r;
            initial begin
                int len, d;
                logic prev;
                echo_r = 1'b0;
                len = 0;
                prev = 1'b0;
                forever begin
                    @(negedge clk);
                    if (trig[g]) begin
                        if (!prev) begin
                            check($sformatf("trig%0d exclusive", g), 32'(trig), 32'(1 << g));
                            if (prev_fall >= 0) begin
                                checks++;
                                if (cyc_n - prev_fall < GAP) begin
                                    fails++;
                                    $display("FAIL trig%0d gap got=%0d exp>=%0d", g, cyc_n - prev_fall, GAP);
                                end
                            end
                        end
                        len++;
                        prev = 1'b1;
                    end else if (prev) begin
                        prev = 1'b0;
                        if (abort_flag[g]) begin
                            abort_flag[g] = 1'b0;
                        end else begin
                            check($sformatf("trig%0d width", g), 32'(len), 32'(TRIG));
                            prev_fall = cyc_n;
                            pulse_cnt[g]++;
                            if (width_a[g] > 0) begin
                                d = $urandom_range(0, 30);
                                repeat (d) @(negedge clk);
                                echo_r = 1'b1;
                                repeat (width_a[g]) @(negedge clk);
                                echo_r = 1'b0;
                            end
                        end
                        len = 0;
                    end
                end
            end
        end
    endgenerate

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [31:0] e, m;
        string nm;
        forever begin
            @(negedge clk);
            if (wb_ack && !wb_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected read ack", wb_dat_o, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    m = msk_q.pop_front();
                    nm = name_q.pop_front();
                    check(nm, wb_dat_o & m, e & m);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wb_xfer(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic w, input string nm);
        int n;
        logic got;
        @(posedge clk);
        #1;
        wb_adr = a; wb_dat = d; wb_sel = s; wb_we = w; wb_cyc = 1'b1; wb_stb = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 16) begin
            @(posedge clk);
            #1;
            n++;
            if (wb_ack) got = 1'b1;
        end
        check({nm, " ack latency"}, 32'(n), 32'd1);
        if (!got && !w && exp_q.size() > 0) begin
            void'(exp_q.pop_back());
            void'(msk_q.pop_back());
            void'(name_q.pop_back());
        end
        @(negedge clk);
        trig_at_ack = trig;
        @(posedge clk);
        #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_xfer(a, d, s, 1'b1, "write");
    endtask

    task automatic wb_read(input logic [5:0] a, input logic [31:0] e, input logic [31:0] m, input string nm);
        exp_q.push_back(e);
        msk_q.push_back(m);
        name_q.push_back(nm);
        wb_xfer(a, 32'd0, 4'hF, 1'b0, nm);
    endtask

    task automatic wait_idle();
        int n;
        repeat (3) @(posedge clk);
        n = 0;
        while (dbg_state != 3'd0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20000) begin
            fails++;
            $display("FAIL idle wait got=busy exp=idle");
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " trig/ack"}, 32'({trig, wb_ack}), 32'd0);
        check({nm, " rdata"}, wb_dat_o, 32'd0);
    endtask

    task automatic read_all_zero(input string nm);
        wb_read(6'h00, 32'd0, 32'hFFFF_FFFF, {nm, " ctrl"});
        wb_read(6'h04, 32'd0, 32'hFFFF_FFFF, {nm, " status"});
        wb_read(6'h10, 32'd0, 32'hFFFF_FFFF, {nm, " result0"});
        wb_read(6'h14, 32'd0, 32'hFFFF_FFFF, {nm, " result1"});
    endtask

    // One single-shot sweep over mask m; expectations come from the echo widths handed to the sensors.
    task automatic run_single(input logic [1:0] m, input int w0, input int w1);
        logic [3:0] e_done, e_tmo;
        int w;
        width_a[0] = w0;
        width_a[1] = w1;
        wb_write(6'h08, 32'hF, 4'h1);
        prev_fall = -1;
        wb_write(6'h00, 32'h5 | (32'(m) << 4), 4'h1);
        wait_idle();
        repeat (300) @(posedge clk);
        e_done = 4'd0;
        e_tmo = 4'd0;
        for (int c = 0; c < N_CH; c++) begin
            if (m[c]) begin
                e_done[c] = 1'b1;
                w = width_a[c];
                if (w == 0) begin
                    e_tmo[c] = 1'b1;
                end else if (w >= TMO) begin
                    e_tmo[c] = 1'b1;
                    exp_res[c] = TMO;
                end else begin
                    exp_res[c] = w;
                end
            end
        end
        wb_read(6'h04, (32'(e_tmo) << 16) | (32'(e_done) << 8), 32'hFFFF_FFF9, "status");
        wb_read(6'h00, 32'h1 | (32'(m) << 4), 32'hFFFF_FFFF, "ctrl");
        wb_read(6'h10, 32'(exp_res[0]), 32'hFFFF_FFFF, "result0");
        wb_read(6'h14, 32'(exp_res[1]), 32'hFFFF_FFFF, "result1");
    endtask

    function automatic int rand_width();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 1) return $urandom_range(TMO, TMO + 50);
        return $urandom_range(1, TMO - 1);
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int p0, p1, n;
        rst = 1'b1;
        wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            width_a[c] = 0;
            pulse_cnt[c] = 0;
            exp_res[c] = 0;
            abort_flag[c] = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        read_all_zero("post-reset");
        wb_read(6'h0C, 32'd0, 32'hFFFF_FFFF, "unmapped 0x0C");
        wb_read(6'h18, 32'd0, 32'hFFFF_FFFF, "result2 absent");

        // Two-channel sweep, then the width boundaries around the timeout.
        run_single(2'b11, $urandom_range(20, 150), $urandom_range(20, 150));
        run_single(2'b01, TMO - 1, 0);
        run_single(2'b01, TMO, 0);
        run_single(2'b01, 0, 0);
        run_single(2'b10, 0, TMO + 50);

        run_single(2'b01, TMO + 50, 0);
        wb_write(6'h08, 32'h1, 4'h1);
        wb_read(6'h04, 32'd0, 32'hFFFF_FFF9, "status after clr");

        // Byte lanes other than 0 must not touch CTRL.
        wb_write(6'h00, 32'h0000_00FF, 4'hE);
        wb_read(6'h00, 32'h11, 32'hFFFF_FFFF, "ctrl sel masked");

        for (int i = 0; i < 5; i++)
            run_single(2'($urandom_range(1, 3)), rand_width(), rand_width());

        // Continuous mode on channel 1 only, then EN cleared in the middle of a trigger.
        width_a[1] = $urandom_range(10, 60);
        prev_fall = -1;
        p0 = pulse_cnt[0];
        p1 = pulse_cnt[1];
        wb_write(6'h00, 32'h23, 4'h1);
        n = 0;
        while (pulse_cnt[1] < p1 + 3 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("cont pulses ch1", 32'(pulse_cnt[1] - p1 >= 3), 32'd1);
        check("cont pulses ch0", 32'(pulse_cnt[0] - p0), 32'd0);
        n = 0;
        while (!trig[1] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("cont trig1 seen", 32'(trig[1]), 32'd1);
        repeat (3) @(negedge clk);
        abort_flag[1] = 1'b1;
        wb_write(6'h00, 32'h22, 4'h1);
        check("trig at EN clear", 32'(trig_at_ack), 32'd0);
        wb_read(6'h04, 32'd0, 32'h0000_0001, "busy after EN clear");
        prev_fall = -1;
        repeat (50) @(posedge clk);

        // Asynchronous reset in the middle of a trigger pulse.
        width_a[0] = 0;
        abort_flag[0] = 1'b1;
        wb_write(6'h00, 32'h15, 4'h1);
        n = 0;
        while (!trig[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("trig0 before reset", 32'(trig[0]), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset in TRIG");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < N_CH; c++) exp_res[c] = 0;
        read_all_zero("after TRIG reset");

        // Asynchronous reset while an echo is being measured.
        run_single(2'b11, 60, 70);
        width_a[0] = 150;
        prev_fall = -1;
        wb_write(6'h00, 32'h15, 4'h1);
        n = 0;
        while (!echo_w[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("echo0 before reset", 32'(echo_w[0]), 32'd1);
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset in MEASURE");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < N_CH; c++) exp_res[c] = 0;
        repeat (200) @(posedge clk);
        read_all_zero("after MEASURE reset");

        repeat (5) @(posedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
